// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter and FSM encodings,
// the table entry layout and the saturating counter step.
package bp_pkg;

   localparam int BP_INDEX_BITS = 6;
   localparam int BP_TAG_BITS   = 8;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_t;

   typedef struct packed {
      logic                   valid;
      logic [BP_TAG_BITS-1:0] tag;
      logic [31:0]            target;
      bp_ctr_t                ctr;
   } bp_entry_t;

   function automatic bp_ctr_t ctr_next(bp_ctr_t ctr, logic taken);
      bp_ctr_t n;
      n = ctr;
      if (taken) begin
         if (ctr != ST) n = bp_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) n = bp_ctr_t'(ctr - 2'd1);
      end
      return n;
   endfunction

endpackage

// File: rtl/bp_table.sv
// BHT/BTB storage: two combinational read ports (fetch, execute),
// one write port and a sweep-clear port that takes priority.
module bp_table
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS
) (
   input  logic                  clk,
   input  logic [INDEX_BITS-1:0] rd_idx_f,
   output bp_entry_t             rd_entry_f,
   input  logic [INDEX_BITS-1:0] rd_idx_e,
   output bp_entry_t             rd_entry_e,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  bp_entry_t             wr_entry,
   input  logic                  clr_en,
   input  logic [INDEX_BITS-1:0] clr_idx
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   bp_entry_t mem [ENTRIES];
   bp_entry_t clr_entry;

   assign rd_entry_f = mem[rd_idx_f];
   assign rd_entry_e = mem[rd_idx_e];

   always_comb begin
      clr_entry        = '0;
      clr_entry.valid  = 1'b0;
      clr_entry.ctr    = WNT;
   end

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_idx] <= clr_entry;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_entry;
      end
   end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Fetch-stage BHT/BTB lookup and execute-stage resolution/redirect.
// Define BP_STATS_EN to add branch and mispredict counters.
module branch_predictor_ctrl
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = BP_INDEX_BITS,
   parameter int TAG_BITS   = BP_TAG_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        predict_taken_f,
   output logic [31:0] predict_target_f,
   input  logic        branch_e,
   input  logic        branch_taken_e,
   input  logic [31:0] pc_e,
   input  logic [31:0] target_e,
   input  logic        pred_taken_e,
   input  logic [31:0] pred_target_e,
   input  logic        stall_e,
   output logic        mispredict_e,
   output logic [31:0] redirect_pc_e,
`ifdef BP_STATS_EN
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts,
`endif
   output logic        init_done
);

   localparam int TAG_LO = INDEX_BITS + 2;
   localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;
   localparam logic [INDEX_BITS-1:0] LAST = '1;
   localparam logic [INDEX_BITS-1:0] ONE  = 1;

   bp_state_t             state;
   bp_state_t             state_n;
   logic [INDEX_BITS-1:0] ptr;
   logic [INDEX_BITS-1:0] ptr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      unique case (state)
         INIT: begin
            ptr_n = ptr + ONE;
            if (ptr == LAST) state_n = RUN;
         end
         RUN: ;
      endcase
   end

   logic                  run;
   logic [INDEX_BITS-1:0] idx_f;
   logic [INDEX_BITS-1:0] idx_e;
   logic [TAG_BITS-1:0]   tag_f;
   logic [TAG_BITS-1:0]   tag_e;
   bp_entry_t             ent_f;
   bp_entry_t             ent_e;
   bp_entry_t             wr_entry;
   logic                  wr_en;
   logic                  clr_en;
   logic                  hit_f;
   logic                  hit_e;
   logic                  qual;
   logic                  upd;

   assign run       = (state == RUN);
   assign init_done = run;
   assign idx_f     = pc_f[TAG_LO-1:2];
   assign idx_e     = pc_e[TAG_LO-1:2];
   assign tag_f     = pc_f[TAG_HI:TAG_LO];
   assign tag_e     = pc_e[TAG_HI:TAG_LO];
   assign clr_en    = !run && !rst;

   bp_table #(
      .INDEX_BITS (INDEX_BITS)
   ) u_table (
      .clk        (clk),
      .rd_idx_f   (idx_f),
      .rd_entry_f (ent_f),
      .rd_idx_e   (idx_e),
      .rd_entry_e (ent_e),
      .wr_en      (wr_en),
      .wr_idx     (idx_e),
      .wr_entry   (wr_entry),
      .clr_en     (clr_en),
      .clr_idx    (ptr)
   );

   // Lookup reads the pre-update entry; there is no write bypass.
   assign hit_f            = run && ent_f.valid && (ent_f.tag == tag_f);
   assign predict_taken_f  = hit_f && ent_f.ctr[1];
   assign predict_target_f = hit_f ? ent_f.target : 32'd0;

   assign qual = run && branch_e && !stall_e;
   assign upd  = qual && !rst;

   assign mispredict_e = qual &&
      ((branch_taken_e != pred_taken_e) ||
       (branch_taken_e && (pred_target_e != target_e)));

   assign redirect_pc_e = !mispredict_e ? 32'd0 :
      (branch_taken_e ? target_e : pc_e + 32'd4);

   assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

   always_comb begin
      wr_en    = 1'b0;
      wr_entry = ent_e;
      if (upd) begin
         if (hit_e) begin
            wr_en        = 1'b1;
            wr_entry.ctr = ctr_next(ent_e.ctr, branch_taken_e);
            if (branch_taken_e) wr_entry.target = target_e;
         end else if (branch_taken_e) begin
            wr_en           = 1'b1;
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = tag_e;
            wr_entry.target = target_e;
            wr_entry.ctr    = WT;
         end
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (qual) begin
         stat_branches <= stat_branches + 32'd1;
         if (mispredict_e) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

   logic unused_pc;
   assign unused_pc = ^{pc_f[1:0], pc_f[31:TAG_HI+1],
                        pc_e[1:0], pc_e[31:TAG_HI+1]};

endmodule
